// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential word fetch, DEPTH-entry instruction FIFO, redirect flush.
// Define FETCHQ_BYPASS_EN to forward a live response straight to decode when the queue is empty.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [31:0]                mem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_data,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];

    logic [31:0]   redir_pc;
    logic [CW:0]   inflight;
    logic          empty;
    logic          req_fire;
    logic          rsp_hit;
    logic          live;
    logic          byp;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    assign redir_pc = {redirect_pc[31:2], 2'b00};
    assign empty    = (count == '0);
    assign inflight = {1'b0, count} + {1'b0, outstanding};

    // Credit: queued plus in-flight never exceeds DEPTH, so a push never meets a full FIFO.
    assign mem_req_valid = !reset && !redirect_valid
                         && (inflight < DEPTH_W);
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_hit = mem_rsp_valid && (outstanding != '0);
    assign live    = rsp_hit && (stale == '0)
                   && !redirect_valid && !reset;

`ifdef FETCHQ_BYPASS_EN
    assign byp = empty && live;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid = !reset && !redirect_valid
                       && (!empty || byp);

    always_comb begin
        instr_data = '0;
        instr_pc   = '0;
        if (!empty) begin
            instr_data = data_q[rd_ptr];
            instr_pc   = pc_q[rd_ptr];
        end else if (byp) begin
            instr_data = mem_rsp_data;
            instr_pc   = rsp_pc;
        end
    end

    assign pop   = instr_valid && instr_ready;
    assign wr_en = live && !(byp && instr_ready);
    assign rd_en = pop && !empty;

    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            // Every fetch still in flight comes back with old-path data.
            fetch_pc    <= redir_pc;
            rsp_pc      <= redir_pc;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= outstanding - CW'(rsp_hit);
            stale       <= outstanding - CW'(rsp_hit);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire)
                         - CW'(rsp_hit);
            if (rsp_hit && (stale != '0)) begin
                stale <= stale - CW'(1);
            end
            if (live) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (wr_en) begin
            data_q[wr_ptr] <= mem_rsp_data;
            pc_q[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: cycle vector table plus fetch/redirect/reset sequences.
// Expectations follow FETCHQ_BYPASS_EN when it is defined.
module tb_instr_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          use_model = 1'b0;
    bit          stall = 1'b0;
    logic [31:0] pend[$];
    logic [31:0] lp[$];
    logic [31:0] ld[$];
    int          lc[$];

    logic        s_rqv;
    logic        s_iv;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_data;
    logic [2:0]  s_occ;

    function automatic vec_t mk(
        input logic rr, input logic rv, input logic [31:0] rd,
        input logic ir, input logic erq, input logic [31:0] ea,
        input logic eiv, input logic [31:0] ep,
        input logic [31:0] ed, input logic [2:0] eo);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
        v.e_rqv = erq; v.e_addr = ea; v.e_iv = eiv;
        v.e_pc = ep; v.e_data = ed; v.e_occ = eo;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (use_model && !stall && pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend[0] ^ K;
            void'(pend.pop_front());
        end else if (use_model) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        #1;
        s_rqv = mem_req_valid; s_addr = mem_req_addr;
        s_iv = instr_valid; s_pc = instr_pc;
        s_data = instr_data; s_occ = occupancy;
        checks++;
        if (occupancy > 3'd4) begin
            failures++;
            $display("FAIL occ_bound actual=%0d required<=4",
                     occupancy);
        end
        if (occupancy == 3'd4 && mem_rsp_valid) begin
            failures++;
            $display("FAIL full_push actual=rsp_on_full required=none");
        end
        if (instr_valid && instr_ready) begin
            lp.push_back(instr_pc);
            ld.push_back(instr_data);
            lc.push_back(cyc);
        end
        if (mem_req_valid && mem_req_ready) begin
            pend.push_back(mem_req_addr);
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        lp.delete(); ld.delete(); lc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pend.delete();
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        redirect_valid = 1'b0; instr_ready = 1'b0;
        mem_req_ready = 1'b0; stall = 1'b0;
        @(negedge clk); #1;
        chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst.instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_log();
    endtask

    task automatic expect_log(input string nm,
                              input logic [31:0] base,
                              input int n);
        logic [31:0] p;
        chk({nm, ".pops"}, 32'(lp.size() >= n), 32'd1);
        for (int i = 0; i < n && i < lp.size(); i++) begin
            p = base + 32'(4 * i);
            chk($sformatf("%s.pc%0d", nm, i), lp[i], p);
            chk($sformatf("%s.data%0d", nm, i), ld[i], p ^ K);
            chk($sformatf("%s.cyc%0d", nm, i),
                32'(lc[i] - lc[0]), 32'(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl.push_back(mk(1,0,0,0, 1,32'h0,0,0,0,0));
        tbl.push_back(mk(1,1,K,0, 1,32'h4,BYP,0,
                         BYP ? K : 32'h0,0));
        tbl.push_back(mk(1,1,K|32'h4,0, 1,32'h8,1,0,K,1));
        tbl.push_back(mk(1,1,K|32'h8,0, 1,32'hC,1,0,K,2));
        tbl.push_back(mk(1,1,K|32'hC,0, 0,32'h10,1,0,K,3));
        tbl.push_back(mk(1,0,0,0, 0,32'h10,1,0,K,4));
        tbl.push_back(mk(0,0,0,1, 0,32'h10,1,0,K,4));
        tbl.push_back(mk(0,0,0,1, 1,32'h10,1,32'h4,K|32'h4,3));
        tbl.push_back(mk(0,0,0,1, 1,32'h10,1,32'h8,K|32'h8,2));
        tbl.push_back(mk(0,0,0,1, 1,32'h10,1,32'hC,K|32'hC,1));
        tbl.push_back(mk(0,0,0,1, 1,32'h10,0,0,0,0));
        tbl.push_back(mk(0,1,32'hDEADBEEF,1, 1,32'h10,0,0,0,0));
        tbl.push_back(mk(0,0,0,1, 1,32'h10,0,0,0,0));

        do_reset();
        use_model = 1'b0;
        foreach (tbl[i]) begin
            mem_req_ready = tbl[i].rr;
            mem_rsp_valid = tbl[i].rv;
            mem_rsp_data  = tbl[i].rd;
            instr_ready   = tbl[i].ir;
            @(negedge clk); #1;
            chk($sformatf("v%0d.req_valid", i),
                32'(mem_req_valid), 32'(tbl[i].e_rqv));
            chk($sformatf("v%0d.req_addr", i),
                mem_req_addr, tbl[i].e_addr);
            chk($sformatf("v%0d.instr_valid", i),
                32'(instr_valid), 32'(tbl[i].e_iv));
            chk($sformatf("v%0d.instr_pc", i),
                instr_pc, tbl[i].e_pc);
            chk($sformatf("v%0d.instr_data", i),
                instr_data, tbl[i].e_data);
            chk($sformatf("v%0d.occ", i),
                32'(occupancy), 32'(tbl[i].e_occ));
            @(posedge clk); #1;
        end

        // Streaming fetch with 1-cycle memory.
        use_model = 1'b1;
        do_reset();
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        step();
        chk("t1.rst_rqv", 32'(s_rqv), 32'd1);
        chk("t1.rst_addr", s_addr, 32'h0);
        chk("t1.rst_iv", 32'(s_iv), 32'd0);
        chk("t1.rst_pc", s_pc, 32'h0);
        chk("t1.rst_data", s_data, 32'h0);
        chk("t1.rst_occ", 32'(s_occ), 32'd0);
        run(7);
        expect_log("t1", 32'h0, 4);

        // Redirect with two fetches in flight.
        do_reset();
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        stall = 1'b1;
        run(2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        chk("t3.redir_rqv", 32'(s_rqv), 32'd0);
        chk("t3.redir_iv", 32'(s_iv), 32'd0);
        redirect_valid = 1'b0; stall = 1'b0;
        clear_log();
        step();
        chk("t3.occ", 32'(s_occ), 32'd0);
        chk("t3.rqv", 32'(s_rqv), 32'd1);
        chk("t3.addr", s_addr, 32'h100);
        run(7);
        expect_log("t3", 32'h100, 2);

        // Redirect near the top of the address space; low bits ignored.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        clear_log();
        step();
        redirect_valid = 1'b0;
        run(9);
        expect_log("t4", 32'hFFFF_FFF8, 3);

        // Redirect in the same cycle as the only outstanding response.
        do_reset();
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        stall = 1'b1;
        step();
        mem_req_ready = 1'b0; stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        clear_log();
        step();
        chk("t5.redir_rqv", 32'(s_rqv), 32'd0);
        chk("t5.redir_iv", 32'(s_iv), 32'd0);
        redirect_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        chk("t5.occ", 32'(s_occ), 32'd0);
        chk("t5.addr", s_addr, 32'h200);
        run(6);
        expect_log("t5", 32'h200, 2);

        // Reset with a partly full queue and a fetch in flight.
        do_reset();
        mem_req_ready = 1'b1; instr_ready = 1'b0;
        run(4);
        chk("t6.pre_occ", 32'(s_occ), 32'd2);
        chk("t6.pre_iv", 32'(s_iv), 32'd1);
        do_reset();
        mem_req_ready = 1'b1;
        step();
        chk("t6.iv", 32'(s_iv), 32'd0);
        chk("t6.occ", 32'(s_occ), 32'd0);
        chk("t6.addr", s_addr, 32'h0);
        chk("t6.rqv", 32'(s_rqv), 32'd1);

        // Response into an empty queue with decode ready.
        do_reset();
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        stall = 1'b1;
        step();
        mem_req_ready = 1'b0; stall = 1'b0;
        step();
        chk("t7.iv", 32'(s_iv), 32'(BYP));
        chk("t7.pc", s_pc, 32'h0);
        chk("t7.data", s_data, BYP ? K : 32'h0);
        step();
        chk("t7.next_occ", 32'(s_occ), BYP ? 32'd0 : 32'd1);
        chk("t7.next_iv", 32'(s_iv), BYP ? 32'd0 : 32'd1);
        chk("t7.next_data", s_data, BYP ? 32'h0 : K);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
